// File: rtl/charge_pkg.sv
// Shared types and arithmetic helpers for the synaptic charge accumulator.
// The helpers work on wide signed values so any charge/weight width up to 31 bits fits.
package charge_pkg;

  localparam int unsigned DEF_N_NEURON   = 256;
  localparam int unsigned DEF_LANES      = 8;
  localparam int unsigned DEF_W_WEIGHT   = 4;
  localparam int unsigned DEF_W_CHARGE   = 8;
  localparam int unsigned DEF_RD_LANES   = 4;
  localparam int unsigned DEF_LEAK_SHIFT = 7;
  localparam int unsigned DEF_SATURATE   = 1;

  localparam int unsigned CALC_W = 32;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAK  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_ACC   = 2'd1,
    OP_LEAK  = 2'd2,
    OP_CLEAR = 2'd3
  } lane_op_e;

  typedef struct packed {
    logic  ovf;
    calc_t value;
  } add_res_t;

  // Add a sign-extended weight to a sign-extended charge; clamp or wrap to w_charge bits.
  function automatic add_res_t sat_add(input calc_t charge, input calc_t weight,
                                       input int unsigned w_charge, input logic saturate);
    add_res_t res;
    calc_t    sum;
    calc_t    hi;
    calc_t    lo;
    sum = charge + weight;
    hi  = (calc_t'(1) <<< (w_charge - 1)) - calc_t'(1);
    lo  = -(calc_t'(1) <<< (w_charge - 1));
    res.ovf = (sum > hi) || (sum < lo);
    if (!res.ovf) begin
      res.value = sum;
    end else if (saturate) begin
      res.value = (sum > hi) ? hi : lo;
    end else begin
      res.value = (sum <<< (CALC_W - w_charge)) >>> (CALC_W - w_charge);
    end
    return res;
  endfunction

  // Exponential decay step; magnitude never grows, so it cannot overflow.
  function automatic calc_t leak_step(input calc_t charge, input int unsigned shift);
    return charge - (charge >>> shift);
  endfunction

endpackage

// File: rtl/charge_lane.sv
// Single-neuron update datapath: accumulate with saturation, leak, or clear.
module charge_lane
  import charge_pkg::*;
#(
  parameter int unsigned W_CHARGE   = DEF_W_CHARGE,
  parameter int unsigned W_WEIGHT   = DEF_W_WEIGHT,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned SATURATE   = DEF_SATURATE
) (
  input  lane_op_e                   op_i,
  input  logic signed [W_CHARGE-1:0] charge_i,
  input  logic signed [W_WEIGHT-1:0] weight_i,
  output logic signed [W_CHARGE-1:0] charge_c,
  output logic                       ovf_c
);

  add_res_t sum;

  always_comb begin
    charge_c = charge_i;
    ovf_c    = 1'b0;
    sum      = sat_add(calc_t'(charge_i), calc_t'(weight_i), W_CHARGE, SATURATE != 0);
    unique case (op_i)
      OP_ACC: begin
        charge_c = W_CHARGE'(sum.value);
        ovf_c    = sum.ovf;
      end
      OP_LEAK:  charge_c = W_CHARGE'(leak_step(calc_t'(charge_i), LEAK_SHIFT));
      OP_CLEAR: charge_c = '0;
      default:  ;
    endcase
  end

endmodule

// File: rtl/charge_accumulator.sv
// Per-neuron synaptic charge registers with handshaked accumulate, leak sweep and clear sweep.
module charge_accumulator
  import charge_pkg::*;
#(
  parameter int unsigned N_NEURON   = DEF_N_NEURON,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned W_WEIGHT   = DEF_W_WEIGHT,
  parameter int unsigned W_CHARGE   = DEF_W_CHARGE,
  parameter int unsigned RD_LANES   = DEF_RD_LANES,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned SATURATE   = DEF_SATURATE
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  acc_valid_i,
  output logic                                  acc_ready_o,
  input  logic [$clog2(N_NEURON/LANES)-1:0]     acc_group_i,
  input  logic [LANES*W_WEIGHT-1:0]             acc_data_i,
  input  logic                                  leak_start_i,
  input  logic                                  clear_i,
  output logic                                  busy_o,
  input  logic [$clog2(N_NEURON/RD_LANES)-1:0]  rd_idx_i,
  output logic [RD_LANES*W_CHARGE-1:0]          rd_data_o,
  output logic                                  sat_o
);

  localparam int unsigned GROUPS = N_NEURON / LANES;
  localparam int unsigned GRP_W  = $clog2(GROUPS);
  localparam int unsigned IDX_W  = $clog2(N_NEURON);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

  state_e                     state_q, state_d;
  logic [GRP_W-1:0]           cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic                       sat_q, sat_d;
  logic                       clr_sat;
  lane_op_e                   lane_op;
  logic [GRP_W-1:0]           grp;
  logic signed [W_CHARGE-1:0] charge_q [N_NEURON];
  logic signed [W_CHARGE-1:0] charge_d [N_NEURON];
  logic signed [W_CHARGE-1:0] lane_in  [LANES];
  logic signed [W_CHARGE-1:0] lane_out [LANES];
  logic [LANES-1:0]           lane_ovf;

  assign acc_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign sat_o       = sat_q;
  assign grp         = (state_q == ST_IDLE) ? acc_group_i : cnt_q;

  // Sequencer: clear beats everything; leak pulses during a sweep merge into one pending sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    clr_sat = 1'b0;
    lane_op = OP_HOLD;
    if (clear_i && (state_q != ST_CLEAR)) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
      pend_d  = 1'b0;
      clr_sat = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (acc_valid_i) lane_op = OP_ACC;
          if (leak_start_i) begin
            state_d = ST_LEAK;
            cnt_d   = '0;
          end
        end
        ST_LEAK: begin
          lane_op = OP_LEAK;
          if (cnt_q == LAST_GRP) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (!(pend_q || leak_start_i)) state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q + GRP_W'(1);
            pend_d = pend_q || leak_start_i;
          end
        end
        ST_CLEAR: begin
          lane_op = OP_CLEAR;
          if (cnt_q == LAST_GRP) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + GRP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_in[k] = charge_q[IDX_W'(32'(grp) * LANES + 32'(k))];

    charge_lane #(
      .W_CHARGE  (W_CHARGE),
      .W_WEIGHT  (W_WEIGHT),
      .LEAK_SHIFT(LEAK_SHIFT),
      .SATURATE  (SATURATE)
    ) u_lane (
      .op_i    (lane_op),
      .charge_i(lane_in[k]),
      .weight_i(acc_data_i[k*W_WEIGHT +: W_WEIGHT]),
      .charge_c(lane_out[k]),
      .ovf_c   (lane_ovf[k])
    );
  end

  // Write the selected group back and track the sticky overflow flag.
  always_comb begin
    charge_d = charge_q;
    sat_d    = sat_q;
    if (lane_op != OP_HOLD) begin
      for (int k = 0; k < LANES; k++) begin
        charge_d[IDX_W'(32'(grp) * LANES + 32'(k))] = lane_out[k];
      end
    end
    if (clr_sat) begin
      sat_d = 1'b0;
    end else if ((lane_op == OP_ACC) && (|lane_ovf)) begin
      sat_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int j = 0; j < RD_LANES; j++) begin
      rd_data_o[j*W_CHARGE +: W_CHARGE] = charge_q[IDX_W'(32'(rd_idx_i) * RD_LANES + 32'(j))];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < N_NEURON; i++) charge_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      sat_q    <= sat_d;
      charge_q <= charge_d;
    end
  end

endmodule

// File: tb/tb_charge_accumulator.sv
// Bench for charge_accumulator: directed scenarios plus random traffic against a behavioural model.
module tb_charge_accumulator;

  localparam int N      = 256;
  localparam int LANES  = 8;
  localparam int WW     = 4;
  localparam int WC     = 8;
  localparam int RDL    = 4;
  localparam int LS     = 7;
  localparam int SAT    = 1;
  localparam int GROUPS = N / LANES;
  localparam int CMAX   = (1 << (WC - 1)) - 1;
  localparam int CMIN   = -(1 << (WC - 1));

  logic        CLK = 1'b0;
  logic        RST;
  logic        acc_valid_i;
  logic        acc_ready_o;
  logic [4:0]  acc_group_i;
  logic [31:0] acc_data_i;
  logic        leak_start_i;
  logic        clear_i;
  logic        busy_o;
  logic [5:0]  rd_idx_i;
  logic [31:0] rd_data_o;
  logic        sat_o;

  always #5 CLK = ~CLK;

  charge_accumulator #(
    .N_NEURON(N), .LANES(LANES), .W_WEIGHT(WW), .W_CHARGE(WC),
    .RD_LANES(RDL), .LEAK_SHIFT(LS), .SATURATE(SAT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .acc_valid_i (acc_valid_i),
    .acc_ready_o (acc_ready_o),
    .acc_group_i (acc_group_i),
    .acc_data_i  (acc_data_i),
    .leak_start_i(leak_start_i),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .rd_idx_i    (rd_idx_i),
    .rd_data_o   (rd_data_o),
    .sat_o       (sat_o)
  );

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model: charges as plain integers, sweep tracked as mode + position.
  int m_chg [N];
  int m_mode;   // 0 idle, 1 leaking, 2 clearing
  int m_pos;
  bit m_pend;
  bit m_sat;

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int lane_w(input logic [31:0] d, input int k);
    logic [31:0] t;
    int w;
    t = d >> (k * WW);
    w = int'(t[3:0]);
    if (w >= 8) w = w - 16;
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input int idx);
    logic [31:0] r;
    logic [31:0] c;
    r = '0;
    for (int j = 0; j < RDL; j++) begin
      c = m_chg[idx * RDL + j];
      r[j*WC +: WC] = c[WC-1:0];
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) m_chg[i] = 0;
      m_mode = 0; m_pos = 0; m_pend = 0; m_sat = 0;
    end else if (clear_i && m_mode != 2) begin
      m_mode = 2; m_pos = 0; m_pend = 0; m_sat = 0;
    end else if (m_mode == 0) begin
      if (acc_valid_i) begin
        for (int k = 0; k < LANES; k++) begin
          int idx, v;
          idx = int'(acc_group_i) * LANES + k;
          v = m_chg[idx] + lane_w(acc_data_i, k);
          if (v > CMAX || v < CMIN) begin
            m_sat = 1;
            if (SAT != 0) v = (v > CMAX) ? CMAX : CMIN;
            else          v = (v > CMAX) ? v - (1 << WC) : v + (1 << WC);
          end
          m_chg[idx] = v;
        end
      end
      if (leak_start_i) begin m_mode = 1; m_pos = 0; end
    end else if (m_mode == 1) begin
      for (int k = 0; k < LANES; k++) begin
        int idx;
        idx = m_pos * LANES + k;
        m_chg[idx] = m_chg[idx] - floor_div(m_chg[idx], 1 << LS);
      end
      if (leak_start_i) m_pend = 1;
      m_pos++;
      if (m_pos == GROUPS) begin
        m_pos = 0;
        if (m_pend) m_pend = 0;
        else        m_mode = 0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) m_chg[m_pos * LANES + k] = 0;
      m_pos++;
      if (m_pos == GROUPS) begin m_pos = 0; m_mode = 0; end
    end
  end

  // Every-cycle comparison against the model, half a cycle after the edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("ready", 32'(acc_ready_o), 32'(m_mode == 0));
      check("busy",  32'(busy_o),      32'(m_mode != 0));
      check("sat",   32'(sat_o),       32'(m_sat));
      check("rd_data", rd_data_o, exp_word(int'(rd_idx_i)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic acc(input int g, input logic [31:0] d);
    acc_valid_i = 1'b1;
    acc_group_i = 5'(g);
    acc_data_i  = d;
    tick();
    acc_valid_i = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string name);
    tick();
    rd_idx_i = 6'(idx);
    #1;
    check(name, rd_data_o, exp);
  endtask

  task automatic count_busy(output int cycles, output int ready_hi);
    cycles = 0;
    ready_hi = 0;
    for (int i = 0; i < 200 && busy_o; i++) begin
      cycles++;
      if (acc_ready_o) ready_hi++;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_n, ready_n, accepted, nz, idle_busy;
    bit was_acc, done, dir;

    RST = 1'b1; acc_valid_i = 1'b0; acc_group_i = '0; acc_data_i = '0;
    leak_start_i = 1'b0; clear_i = 1'b0; rd_idx_i = '0;
    tick();
    chk_en = 1'b1;
    tick();
    RST = 1'b0;

    check("rst_ready", 32'(acc_ready_o), 32'd1);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_sat",   32'(sat_o),       32'd0);
    rd(0, 32'h0, "rst_rd0");

    acc(0, 32'h76543210);
    rd(0, 32'h03020100, "grp0_word0");
    rd(1, 32'h07060504, "grp0_word1");

    acc(31, 32'hFFFFFFFF);
    acc(31, 32'hFFFFFFFF);
    rd(62, 32'hFEFEFEFE, "grp31_word62");
    rd(63, 32'hFEFEFEFE, "grp31_word63");
    check("no_sat_yet", 32'(sat_o), 32'd0);

    repeat (19) acc(1, 32'h7);
    rd(2, (SAT != 0) ? 32'h7F : 32'h85, "sat_clamp");
    check("sat_set", 32'(sat_o), 32'd1);

    RST = 1'b1; tick(); RST = 1'b0;
    repeat (16) acc(0, 32'h68);
    acc(0, 32'h40);
    rd(0, 32'h00006480, "leak_setup");

    leak_start_i = 1'b1; tick(); leak_start_i = 1'b0;
    count_busy(busy_n, ready_n);
    check("leak_len", 32'(busy_n), 32'd32);
    check("leak_ready_low", 32'(ready_n), 32'd0);
    rd(0, 32'h00006481, "leak_result");

    // Second pulse mid-sweep with a beat held from the first sweep cycle.
    leak_start_i = 1'b1; tick(); leak_start_i = 1'b0;
    acc_valid_i = 1'b1; acc_group_i = 5'd2; acc_data_i = 32'h11111111;
    busy_n = 0; accepted = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      leak_start_i = (i == 5);
      if (busy_o) busy_n++;
      was_acc = acc_valid_i && acc_ready_o;
      if (was_acc) accepted++;
      tick();
      if (was_acc) begin acc_valid_i = 1'b0; done = 1; end
    end
    leak_start_i = 1'b0;
    check("pend_len", 32'(busy_n), 32'd64);
    check("held_beat_once", 32'(accepted), 32'd1);
    rd(4, 32'h01010101, "held_beat_data");

    repeat (19) acc(1, 32'h7);
    leak_start_i = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      leak_start_i = (i == 5);
      tick();
    end
    leak_start_i = 1'b0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    count_busy(busy_n, ready_n);
    check("clear_len", 32'(busy_n), 32'd32);
    check("clear_sat", 32'(sat_o), 32'd0);
    nz = 0;
    for (int w = 0; w < N / RDL; w++) begin
      tick();
      rd_idx_i = 6'(w);
      #1;
      if (rd_data_o != 0) nz++;
    end
    check("clear_all_zero", 32'(nz), 32'd0);
    idle_busy = 0;
    repeat (40) begin tick(); if (busy_o) idle_busy++; end
    check("clear_no_pending", 32'(idle_busy), 32'd0);

    acc(3, 32'h12345678);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    repeat (5) tick();
    RST = 1'b1; tick(); RST = 1'b0;
    check("rst_mid_clear_ready", 32'(acc_ready_o), 32'd1);
    check("rst_mid_clear_busy",  32'(busy_o),      32'd0);

    // Random traffic, biased toward one sign at a time so saturation is reached.
    dir = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) dir = ~dir;
      RST          = ($urandom_range(0, 999) == 0);
      clear_i      = ($urandom_range(0, 399) == 0);
      leak_start_i = ($urandom_range(0, 59) == 0);
      acc_valid_i  = !clear_i && ($urandom_range(0, 1) == 1);
      acc_group_i  = 5'($urandom);
      if ($urandom_range(0, 1) == 1) acc_data_i = dir ? 32'h77777777 : 32'h88888888;
      else                           acc_data_i = $urandom;
      rd_idx_i     = 6'($urandom);
      tick();
    end
    RST = 1'b0; clear_i = 1'b0; leak_start_i = 1'b0; acc_valid_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
